// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: credit-limited imem requests, 2-entry decode buffer, squash on redirect.
// Optional FETCH_PERF_EN adds saturating request/squash counters.
module fetch_unit #(
  parameter int                     IMEM_ADDR_W = 10,
  parameter logic [IMEM_ADDR_W-1:0] PC_RESET    = '0
) (
  input  logic                   clk,
  input  logic                   reset_i,
  input  logic                   en_i,
  output logic                   imem_req_v_o,
  output logic [IMEM_ADDR_W-1:0] imem_addr_o,
  input  logic                   imem_req_ready_i,
  input  logic                   imem_resp_v_i,
  input  logic [15:0]            imem_data_i,
  output logic                   instr_v_o,
  output logic [15:0]            instr_o,
  output logic [IMEM_ADDR_W-1:0] instr_pc_o,
  input  logic                   instr_yumi_i,
  input  logic                   jump_now_i,
  input  logic [IMEM_ADDR_W-1:0] jump_target_i
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]            perf_fetch_o,
  output logic [31:0]            perf_squash_o
`endif
);

  typedef enum logic {IDLE = 1'b0, FETCH = 1'b1} state_e;

  state_e                 state_q, state_d;
  logic [IMEM_ADDR_W-1:0] pc_q;
  logic [1:0]             outst_q, squash_q, cnt_q;
  logic [IMEM_ADDR_W-1:0] ifq_pc [2];
  logic                   ifq_wr, ifq_rd;
  logic [15:0]            buf_data [2];
  logic [IMEM_ADDR_W-1:0] buf_pc [2];
  logic                   buf_wr, buf_rd;
  logic                   accept, drop, push, pop;

  always_ff @(posedge clk) begin
    if (reset_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (en_i)  state_d = FETCH;
      FETCH:   if (!en_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Squashed-but-outstanding requests still hold credit until their response returns.
  always_comb begin
    imem_req_v_o = (state_q == FETCH) && en_i && !jump_now_i &&
                   (({1'b0, outst_q} + {1'b0, cnt_q}) < 3'd2);
  end

  assign imem_addr_o = pc_q;
  assign instr_v_o   = (cnt_q != 2'd0);
  assign instr_o     = instr_v_o ? buf_data[buf_rd] : '0;
  assign instr_pc_o  = instr_v_o ? buf_pc[buf_rd]   : '0;

  assign accept = imem_req_v_o & imem_req_ready_i;
  assign drop   = imem_resp_v_i & ((squash_q != 2'd0) | jump_now_i);
  assign push   = imem_resp_v_i & ~drop;
  assign pop    = instr_yumi_i & instr_v_o & ~jump_now_i;

  always_ff @(posedge clk) begin
    if (reset_i) begin
      pc_q     <= PC_RESET;
      outst_q  <= '0;
      squash_q <= '0;
      cnt_q    <= '0;
      ifq_wr   <= 1'b0;
      ifq_rd   <= 1'b0;
      buf_wr   <= 1'b0;
      buf_rd   <= 1'b0;
    end else begin
      outst_q <= outst_q + 2'(accept) - 2'(imem_resp_v_i);
      ifq_wr  <= ifq_wr ^ accept;
      ifq_rd  <= ifq_rd ^ imem_resp_v_i;
      if (jump_now_i) begin
        // A same-cycle response retires against the old outstanding count.
        pc_q     <= jump_target_i;
        squash_q <= outst_q - 2'(imem_resp_v_i);
        cnt_q    <= '0;
        buf_wr   <= 1'b0;
        buf_rd   <= 1'b0;
      end else begin
        if (accept) pc_q <= pc_q + 1'b1;
        if (imem_resp_v_i && squash_q != 2'd0) squash_q <= squash_q - 2'd1;
        cnt_q  <= cnt_q + 2'(push) - 2'(pop);
        buf_wr <= buf_wr ^ push;
        buf_rd <= buf_rd ^ pop;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) ifq_pc[ifq_wr] <= pc_q;
    if (push) begin
      buf_data[buf_wr] <= imem_data_i;
      buf_pc[buf_wr]   <= ifq_pc[ifq_rd];
    end
  end

`ifdef FETCH_PERF_EN
  logic [1:0]  sq_inc;
  logic [32:0] fetch_sum, squash_sum;

  always_comb begin
    sq_inc     = 2'(drop) + (jump_now_i ? cnt_q : 2'd0);
    fetch_sum  = {1'b0, perf_fetch_o}  + 33'(accept);
    squash_sum = {1'b0, perf_squash_o} + 33'(sq_inc);
  end

  always_ff @(posedge clk) begin
    if (reset_i) begin
      perf_fetch_o  <= '0;
      perf_squash_o <= '0;
    end else begin
      perf_fetch_o  <= fetch_sum[32]  ? '1 : fetch_sum[31:0];
      perf_squash_o <= squash_sum[32] ? '1 : squash_sum[31:0];
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized scoreboard bench for fetch_unit: in-order imem model with epoch-tagged
// requests; expected decode stream queued on response landing, checked on consume.
module tb_fetch_unit;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          reset_i, en_i, ready, resp_v, yumi, jump;
  logic [15:0]   data;
  logic [AW-1:0] target;
  logic          req_v, instr_v;
  logic [AW-1:0] addr, instr_pc;
  logic [15:0]   instr;
`ifdef FETCH_PERF_EN
  logic [31:0]   perf_fetch, perf_squash;
`endif

  fetch_unit #(.IMEM_ADDR_W(AW), .PC_RESET('0)) dut (
    .clk(clk), .reset_i(reset_i), .en_i(en_i),
    .imem_req_v_o(req_v), .imem_addr_o(addr), .imem_req_ready_i(ready),
    .imem_resp_v_i(resp_v), .imem_data_i(data),
    .instr_v_o(instr_v), .instr_o(instr), .instr_pc_o(instr_pc),
    .instr_yumi_i(yumi), .jump_now_i(jump), .jump_target_i(target)
`ifdef FETCH_PERF_EN
    , .perf_fetch_o(perf_fetch), .perf_squash_o(perf_squash)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {logic [AW-1:0] addr; int due; int epoch;} mreq_t;
  mreq_t         mem_q[$];
  logic [AW-1:0] exp_buf[$];
  int checks = 0, failures = 0;
  int cyc = 0, epoch = 0, first_v = -1, accepts = 0, squashes = 0;
  int lat = 1, p_ready = 100, p_yumi = 100, p_jump = 0, p_en = 100;
  bit in_rst = 1'b1, force_jump = 1'b0, jump_prev = 1'b0;
  logic          en_prev = 1'b0;
  logic [AW-1:0] exp_fetch = '0, force_tgt = '0;

  function automatic logic [15:0] mem_data(logic [AW-1:0] a);
    return {6'b101101, a};
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic drive();
    resp_v = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
    data   = resp_v ? mem_data(mem_q[0].addr) : 16'h0;
    ready  = ($urandom_range(99, 0) < p_ready);
    en_i   = ($urandom_range(99, 0) < p_en);
    jump   = force_jump || ($urandom_range(99, 0) < p_jump);
    target = force_jump ? force_tgt : AW'($urandom);
    force_jump = 1'b0;
    yumi   = instr_v && ($urandom_range(99, 0) < p_yumi);
  endtask

  task automatic run(int n);
    repeat (n) begin
      drive();
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: expectations computed first, then model state advanced for this cycle.
  always @(negedge clk) begin
    if (!in_rst) begin
      mreq_t m;
      logic exp_req;
      exp_req = en_prev && en_i && !jump && ((mem_q.size() + exp_buf.size()) < 2);
      check("req_v", req_v, exp_req);
      check("instr_v", instr_v, exp_buf.size() > 0);
      if (jump_prev) check("flush_v", instr_v, 1'b0);
      if (req_v) check("req_addr", addr, exp_fetch);
      if (instr_v && first_v < 0) first_v = cyc;
      if (yumi && instr_v && !jump && exp_buf.size() > 0) begin
        check("instr_pc", instr_pc, exp_buf[0]);
        check("instr", instr, mem_data(exp_buf[0]));
        void'(exp_buf.pop_front());
      end
      if (req_v && ready) begin
        mem_q.push_back('{addr: exp_fetch, due: cyc + lat, epoch: epoch});
        exp_fetch = exp_fetch + 1'b1;
        accepts++;
      end
      if (resp_v && mem_q.size() > 0) begin
        m = mem_q.pop_front();
        if (m.epoch == epoch && !jump) begin
          check("buf_room", exp_buf.size() < 2, 1'b1);
          exp_buf.push_back(m.addr);
        end else squashes++;
      end
      if (jump) begin
        squashes += exp_buf.size();
        exp_buf.delete();
        exp_fetch = target;
        epoch++;
      end
      jump_prev = jump;
      en_prev   = en_i;
      cyc++;
    end
  end

  initial begin
    reset_i = 1'b1; en_i = 1'b1; ready = 1'b1; resp_v = 1'b0; data = '0;
    yumi = 1'b0; jump = 1'b0; target = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req_v", req_v, 1'b0);
    check("rst_addr", addr, '0);
    check("rst_instr_v", instr_v, 1'b0);
    check("rst_instr", instr, '0);
    check("rst_instr_pc", instr_pc, '0);
    @(posedge clk);
    #1;
    reset_i = 1'b0;
    in_rst  = 1'b0;

    // Streaming, 1-cycle memory, continuous consume
    run(20);
    check("first_valid_cycle", first_v, 3);

    // Decode stalls: credits fill, requests stop
    p_yumi = 0;
    run(12);
    check("stall_req_v", req_v, 1'b0);
    check("stall_instr_v", instr_v, 1'b1);
    p_yumi = 100;
    run(5);

    // Latency 3, redirect to 0x040 with two requests in flight
    lat = 3;
    for (int i = 0; i < 20 && mem_q.size() != 2; i++) run(1);
    check("two_outstanding", mem_q.size(), 2);
    force_jump = 1'b1; force_tgt = 10'h040;
    run(15);

    // Redirect near the top of the address space; coincides with response + yumi
    lat = 1;
    run(10);
    force_jump = 1'b1; force_tgt = 10'h3FE;
    run(8);

    // Drop enable with a request outstanding
    lat = 3;
    run(4);
    p_en = 0;
    run(8);
    p_en = 100;
    run(4);

    // Randomized mix
    p_ready = 70; p_yumi = 60; p_jump = 5; p_en = 90;
    for (int s = 0; s < 10; s++) begin
      lat = $urandom_range(4, 1);
      run(300);
    end

`ifdef FETCH_PERF_EN
    check("perf_fetch", perf_fetch, accepts);
    check("perf_squash", perf_squash, squashes);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
